// File: rtl/uart_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cfg
//  Purpose  : Full-duplex UART with configurable data width, parity, stop bits
//             and bit period. Rx has a synchroniser, glitch rejection, and a
//             holding register with ack handshake and sticky error flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart_cfg #(
    parameter int CLKS_PER_BIT = 3125,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clkin,
    input  logic                 rstin,
    input  logic [DATA_BITS-1:0] txdatain,
    input  logic                 txrdyin,
    output logic                 txrdyout,
    output logic                 txout,
    input  logic                 rxin,
    input  logic                 rxackin,
    output logic [DATA_BITS-1:0] rxdataout,
    output logic                 rxrdyout,
    output logic [2:0]           rxerrout
);

    localparam logic [15:0] C_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] C_HALF      = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]  C_DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic        C_STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic        C_ODD       = (PARITY == 1);
    localparam logic        C_HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // ------------------------------------------------------------------ TX
    state_t                tx_state_q, tx_state_d;
    logic [15:0]           tx_cnt_q, tx_cnt_d;
    logic [2:0]            tx_bit_q, tx_bit_d;
    logic                  tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_line_q, tx_line_d;
    logic                  tx_rdy_q, tx_rdy_d;
    logic                  w_tx_bit_end;

    assign w_tx_bit_end = (tx_cnt_q == C_BIT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        tx_rdy_d   = tx_rdy_q;
        if (tx_state_q != S_IDLE) begin
            tx_cnt_d = w_tx_bit_end ? 16'd0 : tx_cnt_q + 16'd1;
        end
        case (tx_state_q)
            S_IDLE: begin
                if (txrdyin && tx_rdy_q) begin
                    tx_shift_d = txdatain;
                    tx_par_d   = (^txdatain) ^ C_ODD;
                    tx_line_d  = 1'b0;
                    tx_rdy_d   = 1'b0;
                    tx_cnt_d   = 16'd0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (w_tx_bit_end) begin
                    tx_line_d  = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = 3'd0;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tx_bit_end) begin
                    if (tx_bit_q == C_DATA_LAST) begin
                        tx_stop_d = 1'b0;
                        if (C_HAS_PAR) begin
                            tx_line_d  = tx_par_q;
                            tx_state_d = S_PAR;
                        end else begin
                            tx_line_d  = 1'b1;
                            tx_state_d = S_STOP;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_line_d  = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end
            end
            S_PAR: begin
                if (w_tx_bit_end) begin
                    tx_line_d  = 1'b1;
                    tx_stop_d  = 1'b0;
                    tx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tx_bit_end) begin
                    if (tx_stop_q == C_STOP_LAST) begin
                        tx_rdy_d   = 1'b1;
                        tx_state_d = S_IDLE;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rstin) begin
        if (!rstin) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_rdy_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
            tx_rdy_q   <= tx_rdy_d;
        end
    end

    assign txout    = tx_line_q;
    assign txrdyout = tx_rdy_q;

    // ------------------------------------------------------------------ RX
    logic                  rx_meta_q, rx_sync_q;
    state_t                rx_state_q, rx_state_d;
    logic [15:0]           rx_cnt_q, rx_cnt_d;
    logic [2:0]            rx_bit_q, rx_bit_d;
    logic                  rx_stop_q, rx_stop_d;
    logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
    logic                  rx_frm_q, rx_frm_d;
    logic                  rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_rdy_q, rx_rdy_d;
    logic [2:0]            rx_err_q, rx_err_d;
    logic                  w_rx_bit_end;
    logic                  w_deliver;
    logic                  w_frm_now;

    assign w_rx_bit_end = (rx_cnt_q == C_BIT_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_stop_d  = rx_stop_q;
        rx_shift_d = rx_shift_q;
        rx_frm_d   = rx_frm_q;
        rx_par_d   = rx_par_q;
        w_deliver  = 1'b0;
        w_frm_now  = rx_frm_q;
        case (rx_state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    rx_cnt_d   = 16'd0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                // Half a bit in: a line back high means a glitch, not a start.
                if (rx_cnt_q == C_HALF) begin
                    rx_cnt_d = 16'd0;
                    if (rx_sync_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_bit_d   = 3'd0;
                        rx_frm_d   = 1'b0;
                        rx_par_d   = 1'b0;
                        rx_state_d = S_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (w_rx_bit_end) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == C_DATA_LAST) begin
                        rx_stop_d  = 1'b0;
                        rx_state_d = C_HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            S_PAR: begin
                if (w_rx_bit_end) begin
                    rx_cnt_d   = 16'd0;
                    rx_par_d   = rx_sync_q ^ (^rx_shift_q) ^ C_ODD;
                    rx_stop_d  = 1'b0;
                    rx_state_d = S_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (w_rx_bit_end) begin
                    rx_cnt_d  = 16'd0;
                    w_frm_now = rx_frm_q | ~rx_sync_q;
                    rx_frm_d  = w_frm_now;
                    if (rx_stop_q == C_STOP_LAST) begin
                        w_deliver  = 1'b1;
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_stop_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Holding register: an ack in the delivery cycle hands over to the new frame.
    always_comb begin
        rx_data_d = rx_data_q;
        rx_rdy_d  = rx_rdy_q;
        rx_err_d  = rx_err_q;
        if (w_deliver) begin
            if (!rx_rdy_q || rxackin) begin
                rx_data_d = rx_shift_q;
                rx_rdy_d  = 1'b1;
                rx_err_d  = (rxackin ? 3'b000 : rx_err_q) | {1'b0, rx_par_q, w_frm_now};
            end else begin
                rx_err_d = rx_err_q | 3'b100;
            end
        end else if (rxackin && rx_rdy_q) begin
            rx_rdy_d = 1'b0;
            rx_err_d = 3'b000;
        end
    end

    always_ff @(posedge clkin or negedge rstin) begin
        if (!rstin) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_stop_q  <= 1'b0;
            rx_shift_q <= '0;
            rx_frm_q   <= 1'b0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_rdy_q   <= 1'b0;
            rx_err_q   <= 3'b000;
        end else begin
            rx_meta_q  <= rxin;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_stop_q  <= rx_stop_d;
            rx_shift_q <= rx_shift_d;
            rx_frm_q   <= rx_frm_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_rdy_q   <= rx_rdy_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign rxdataout = rx_data_q;
    assign rxrdyout  = rx_rdy_q;
    assign rxerrout  = rx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cfg
//  Purpose  : Scoreboard bench for uart_cfg: an 8N1 instance in tx->rx loopback
//             and a 7E2 instance driven by a serial frame generator.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_cfg;

    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: 8N1, rx fed from its own tx
    logic [7:0] a_txdata;
    logic       a_txrdyin, a_txrdyout, a_txout, a_rxin;
    logic       a_rxack = 1'b0;
    logic [7:0] a_rxdata;
    logic       a_rxrdy;
    logic [2:0] a_rxerr;

    // Instance B: 7 data bits, even parity, 2 stop bits
    logic [6:0] b_txdata;
    logic       b_txrdyin, b_txrdyout, b_txout, b_rxin;
    logic       b_rxack;
    logic [6:0] b_rxdata;
    logic       b_rxrdy;
    logic [2:0] b_rxerr;
    logic       b_drv, b_loop;

    assign a_rxin = a_txout;
    assign b_rxin = b_loop ? b_txout : b_drv;

    uart_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .clkin(clk), .rstin(rst_n),
        .txdatain(a_txdata), .txrdyin(a_txrdyin), .txrdyout(a_txrdyout), .txout(a_txout),
        .rxin(a_rxin), .rxackin(a_rxack),
        .rxdataout(a_rxdata), .rxrdyout(a_rxrdy), .rxerrout(a_rxerr)
    );

    uart_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut_b (
        .clkin(clk), .rstin(rst_n),
        .txdatain(b_txdata), .txrdyin(b_txrdyin), .txrdyout(b_txrdyout), .txout(b_txout),
        .rxin(b_rxin), .rxackin(b_rxack),
        .rxdataout(b_rxdata), .rxrdyout(b_rxrdy), .rxerrout(b_rxerr)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] d, input logic [2:0] e);
        exp_t x;
        x.data = d;
        x.err  = e;
        q_a.push_back(x);
    endtask

    task automatic push_b(input logic [6:0] d, input logic [2:0] e);
        exp_t x;
        x.data = {1'b0, d};
        x.err  = e;
        q_b.push_back(x);
    endtask

    // Frame generator for B: start, 7 data LSB first, even parity, 2 stops.
    task automatic send_b(input logic [6:0] d, input logic flip_par, input logic bad_stop);
        logic [10:0] bits;
        logic        p;
        p    = (^d) ^ flip_par;
        bits = {1'b1, ~bad_stop, p, d, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 11; i++) begin
            b_drv = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        b_drv = 1'b1;
    endtask

    task automatic ack_b();
        @(posedge clk); #1 b_rxack = 1'b1;
        @(posedge clk); #1 b_rxack = 1'b0;
    endtask

    // Monitors: a delivery shows as rxrdyout rising, or staying high after an ack.
    logic a_prev_rdy = 1'b0, a_prev_ack = 1'b0;
    logic b_prev_rdy = 1'b0, b_prev_ack = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (a_rxrdy && (!a_prev_rdy || a_prev_ack)) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_rx_unexpected: got data 0x%0h, expected no delivery", a_rxdata);
            end else begin
                e = q_a.pop_front();
                check("a_rx_data", 32'(a_rxdata), 32'(e.data));
                check("a_rx_err", 32'(a_rxerr), 32'(e.err));
            end
        end
        a_prev_rdy = a_rxrdy;
        a_prev_ack = a_rxack;
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_rxrdy && (!b_prev_rdy || b_prev_ack)) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_rx_unexpected: got data 0x%0h, expected no delivery", b_rxdata);
            end else begin
                e = q_b.pop_front();
                check("b_rx_data", 32'(b_rxdata), 32'(e.data));
                check("b_rx_err", 32'(b_rxerr), 32'(e.err));
            end
        end
        b_prev_rdy = b_rxrdy;
        b_prev_ack = b_rxack;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_a5;
        int         low;
        exp_a5    = 10'b1101001010;
        rst_n     = 1'b0;
        a_txdata  = 8'h00;
        a_txrdyin = 1'b0;
        b_txdata  = 7'h00;
        b_txrdyin = 1'b0;
        b_rxack   = 1'b0;
        b_drv     = 1'b1;
        b_loop    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_a_txout", 32'(a_txout), 32'd1);
        check("rst_a_txrdy", 32'(a_txrdyout), 32'd1);
        check("rst_a_rxdata", 32'(a_rxdata), 32'd0);
        check("rst_a_rxrdy", 32'(a_rxrdy), 32'd0);
        check("rst_a_rxerr", 32'(a_rxerr), 32'd0);
        check("rst_b_txout", 32'(b_txout), 32'd1);
        check("rst_b_txrdy", 32'(b_txrdyout), 32'd1);
        check("rst_b_rxdata", 32'(b_rxdata), 32'd0);
        check("rst_b_rxrdy", 32'(b_rxrdy), 32'd0);
        check("rst_b_rxerr", 32'(b_rxerr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 8N1 transmit of 0xA5; later data change must not leak into the frame
        push_a(8'hA5, 3'b000);
        #1 a_txdata = 8'hA5; a_txrdyin = 1'b1;
        @(posedge clk); #1 a_txrdyin = 1'b0; a_txdata = 8'hFF;
        low = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (a_txrdyout) break;
            if ((n % 16) == 8) check($sformatf("a_txbit%0d", n / 16), 32'(a_txout), 32'(exp_a5[n / 16]));
            low++;
        end
        check("a_tx_busy_cycles", 32'(low), 32'd160);
        check("a_rxrdy_held", 32'(a_rxrdy), 32'd1);

        // Asynchronous reset in the middle of a frame
        @(posedge clk); #1 a_txdata = 8'h96; a_txrdyin = 1'b1;
        @(posedge clk); #1 a_txrdyin = 1'b0;
        repeat (60) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_a_txout", 32'(a_txout), 32'd1);
        check("midrst_a_txrdy", 32'(a_txrdyout), 32'd1);
        check("midrst_a_rxdata", 32'(a_rxdata), 32'd0);
        check("midrst_a_rxrdy", 32'(a_rxrdy), 32'd0);
        check("midrst_a_rxerr", 32'(a_rxerr), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        push_a(8'hC3, 3'b000);
        #1 a_txdata = 8'hC3; a_txrdyin = 1'b1;
        @(posedge clk); #1 a_txrdyin = 1'b0;
        repeat (200) @(posedge clk);
        check("a_txrdy_after_c3", 32'(a_txrdyout), 32'd1);

        // 7E2 loopback with txrdyin held for two frames
        b_loop = 1'b1;
        push_b(7'h5A, 3'b000);
        push_b(7'h2B, 3'b000);
        @(posedge clk); #1 b_txdata = 7'h5A; b_txrdyin = 1'b1;
        @(posedge clk); #1 b_txdata = 7'h2B;
        low = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (b_txrdyout) break;
            low++;
        end
        check("b_tx_busy_cycles", 32'(low), 32'd176);
        @(posedge clk); #1 b_txrdyin = 1'b0;
        @(negedge clk);
        check("b_tx_backtoback", 32'(b_txrdyout), 32'd0);
        ack_b();
        @(negedge clk);
        check("b_ack_clears_rdy", 32'(b_rxrdy), 32'd0);
        repeat (200) @(posedge clk);
        ack_b();
        b_loop = 1'b0;
        repeat (4) @(posedge clk);

        // Parity error, then framing error on the first stop bit
        push_b(7'h3C, 3'b010);
        send_b(7'h3C, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        ack_b();
        push_b(7'h3C, 3'b001);
        send_b(7'h3C, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        ack_b();
        @(negedge clk);
        check("b_ack_clears_err", 32'(b_rxerr), 32'd0);

        // Overrun: second frame dropped while first is unacknowledged
        push_b(7'h11, 3'b000);
        send_b(7'h11, 1'b0, 1'b0);
        send_b(7'h22, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("ovr_data_kept", 32'(b_rxdata), 32'h11);
        check("ovr_rdy", 32'(b_rxrdy), 32'd1);
        check("ovr_err", 32'(b_rxerr), 32'b100);
        ack_b();
        @(negedge clk);
        check("ovr_ack_rdy", 32'(b_rxrdy), 32'd0);
        check("ovr_ack_err", 32'(b_rxerr), 32'd0);

        // Ack in the exact delivery cycle of the second frame: no overrun
        push_b(7'h11, 3'b000);
        send_b(7'h11, 1'b0, 1'b0);
        push_b(7'h22, 3'b000);
        fork
            send_b(7'h22, 1'b0, 1'b0);
            begin
                @(posedge clk);
                repeat (170) @(posedge clk);
                #1 b_rxack = 1'b1;
                @(posedge clk);
                #1 b_rxack = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("ackdel_data", 32'(b_rxdata), 32'h22);
        check("ackdel_rdy", 32'(b_rxrdy), 32'd1);
        check("ackdel_err", 32'(b_rxerr), 32'd0);
        ack_b();

        // 5-cycle glitch, then a valid frame
        @(posedge clk); #1 b_drv = 1'b0;
        repeat (5) @(posedge clk);
        #1 b_drv = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("glitch_rdy", 32'(b_rxrdy), 32'd0);
        check("glitch_err", 32'(b_rxerr), 32'd0);
        push_b(7'h35, 3'b000);
        send_b(7'h35, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        ack_b();
        repeat (20) @(posedge clk);

        check("a_scoreboard_empty", 32'(q_a.size()), 32'd0);
        check("b_scoreboard_empty", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
